// File: rtl/five_bit_down_counter.sv
// five_bit_down_counter
//   Down counter for the snake game (move timer, respawn delay and similar).
//   It counts from a runtime limit `max` down to 0 and then wraps back to
//   `max`. It advances once per debounced button press, and a reload
//   request forces the count back to `max`.
//
// Ports
//   clock    system clock, rising edge
//   resetn   synchronous active-low reset
//   max      reload / wrap value, sampled whenever it is used
//   load     reload request (count <= max), wins over a step
//   btn_raw  raw asynchronous push-button level, active-high
//   count    registered count
//   zero     registered (count == 0)
//   wrap     one-cycle pulse when a step takes count 0 -> max
//
// Configuration macro
//   AUTO_TICK_EN  adds a free-running prescaler. It produces an extra step
//                 every TICK_DIV clocks, and load also clears it.
module five_bit_down_counter #(
    parameter int WIDTH     = 5,
    parameter int DB_CYCLES = 16,
    parameter int TICK_DIV  = 1000
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] max,
    input  logic             load,
    input  logic             btn_raw,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             wrap
);

    localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        DB_LOW,
        DB_ARM_HIGH,
        DB_HIGH,
        DB_ARM_LOW
    } db_state_t;

    // Two-flop synchroniser for the raw button pin.
    logic btn_meta, btn_s;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= btn_raw;
            btn_s    <= btn_meta;
        end
    end

    // Debouncer FSM
    db_state_t      db_state, db_prev, db_next;
    logic [DBW-1:0] db_cnt, db_cnt_next;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            db_state <= DB_LOW;
            db_prev  <= DB_LOW;
            db_cnt   <= '0;
        end else begin
            db_state <= db_next;
            db_prev  <= db_state;
            db_cnt   <= db_cnt_next;
        end
    end

    always_comb begin
        db_next     = db_state;
        db_cnt_next = db_cnt;
        case (db_state)
            DB_LOW: begin
                db_cnt_next = '0;
                if (btn_s) db_next = DB_ARM_HIGH;
            end
            DB_ARM_HIGH: begin
                if (!btn_s) begin
                    db_next     = DB_LOW;
                    db_cnt_next = '0;
                end else if (db_cnt == DB_LAST) begin
                    db_next     = DB_HIGH;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end
            DB_HIGH: begin
                db_cnt_next = '0;
                if (!btn_s) db_next = DB_ARM_LOW;
            end
            DB_ARM_LOW: begin
                if (btn_s) begin
                    db_next     = DB_HIGH;
                    db_cnt_next = '0;
                end else if (db_cnt == DB_LAST) begin
                    db_next     = DB_LOW;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end
            default: begin
                db_next     = DB_LOW;
                db_cnt_next = '0;
            end
        endcase
    end

    // A press is the single cycle after the ARM_HIGH -> HIGH transition.
    // A bounce back to HIGH out of ARM_LOW does not count, so holding the
    // button steps only once.
    logic btn_step;
    assign btn_step = (db_state == DB_HIGH) && (db_prev == DB_ARM_HIGH);

    logic tick;
`ifdef AUTO_TICK_EN
    localparam int PW = $clog2(TICK_DIV + 1);
    logic [PW-1:0] presc;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clock) begin
        if (!resetn || load || tick) presc <= '0;
        else                         presc <= presc + 1'b1;
    end
`else
    assign tick = 1'b0;
`endif

    // A coincident button press and tick merge into a single step.
    logic step;
    assign step = btn_step | tick;

    // Count next-state, listed in priority order. Reset is folded in here
    // so that zero is always derived from the value being registered.
    logic [WIDTH-1:0] count_next;
    logic             wrap_next;

    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        if (!resetn) begin
            count_next = max;
        end else if (load) begin
            count_next = max;          // a same-cycle step is dropped
        end else if (step) begin
            if (count == '0) begin
                count_next = max;
                wrap_next  = 1'b1;
            end else if (count > max) begin
                count_next = max;      // limit lowered below current count
            end else begin
                count_next = count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        count <= count_next;
        wrap  <= wrap_next;
        zero  <= (count_next == '0);
    end

endmodule

// File: tb/tb_five_bit_down_counter.sv
module tb_five_bit_down_counter;

    localparam int DB = 4;
    localparam int TD = 10;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] max_in = 5'd5;
    logic       load = 1'b0;
    logic       btn_raw = 1'b0;
    logic [4:0] count;
    logic       zero, wrap;

    int checks = 0;
    int failures = 0;
    logic [4:0] model_cnt;

    typedef struct {
        logic [4:0] cnt;
        logic       z;
        logic       w;
    } exp_t;
    exp_t sb[$];

    five_bit_down_counter #(.WIDTH(5), .DB_CYCLES(DB), .TICK_DIV(TD)) dut (
        .clock(clock), .resetn(resetn), .max(max_in), .load(load),
        .btn_raw(btn_raw), .count(count), .zero(zero), .wrap(wrap)
    );

    always #5 clock = ~clock;

    task automatic step_clk();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] m);
        max_in = m;
        resetn = 1'b0;
        btn_raw = 1'b0;
        load = 1'b0;
        step_clk();
        resetn = 1'b1;
        model_cnt = m;
        checks++;
        if (count !== m || zero !== (m == 5'd0) || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset: count=%0d zero=%0b wrap=%0b want count=%0d zero=%0b wrap=0",
                     count, zero, wrap, m, (m == 5'd0));
        end
    endtask

    task automatic do_load();
        load = 1'b1;
        step_clk();
        load = 1'b0;
        model_cnt = max_in;
        checks++;
        if (count !== max_in || wrap !== 1'b0) begin
            failures++;
            $display("FAIL load: count=%0d wrap=%0b want count=%0d wrap=0", count, wrap, max_in);
        end
    endtask

    // One clean press. btn_raw rises before edge 0; the count must be
    // untouched after edge DB+2 and updated after edge DB+3. With with_load
    // set, load is raised in exactly the cycle the step completes.
    task automatic press(input bit with_load, input string tag);
        exp_t e;
        if (with_load)                e = '{max_in, 1'b0, 1'b0};
        else if (model_cnt == 5'd0)   e = '{max_in, 1'b0, 1'b1};
        else if (model_cnt > max_in)  e = '{max_in, 1'b0, 1'b0};
        else                          e = '{model_cnt - 5'd1, 1'b0, 1'b0};
        e.z = (e.cnt == 5'd0);
        sb.push_back(e);

        btn_raw = 1'b1;
        repeat (DB + 3) step_clk();
        checks++;
        if (count !== model_cnt || zero !== (model_cnt == 5'd0) || wrap !== 1'b0) begin
            failures++;
            $display("FAIL %s_latency: count=%0d zero=%0b wrap=%0b want count=%0d (unchanged)",
                     tag, count, zero, wrap, model_cnt);
        end
        if (with_load) load = 1'b1;
        step_clk();
        load = 1'b0;
        e = sb.pop_front();
        checks++;
        if (count !== e.cnt || zero !== e.z || wrap !== e.w) begin
            failures++;
            $display("FAIL %s_step: count=%0d zero=%0b wrap=%0b want count=%0d zero=%0b wrap=%0b",
                     tag, count, zero, wrap, e.cnt, e.z, e.w);
        end
        model_cnt = e.cnt;
        step_clk();
        checks++;
        if (wrap !== 1'b0 || count !== model_cnt) begin
            failures++;
            $display("FAIL %s_pulse: count=%0d wrap=%0b want count=%0d wrap=0",
                     tag, count, wrap, model_cnt);
        end
        repeat (2) step_clk();
        btn_raw = 1'b0;
        repeat (12) step_clk();
        checks++;
        if (count !== model_cnt || zero !== (model_cnt == 5'd0)) begin
            failures++;
            $display("FAIL %s_hold: count=%0d zero=%0b want count=%0d", tag, count, zero, model_cnt);
        end
    endtask

    task automatic test_reset();
        do_reset(5'd5);
        // A partial press is discarded when reset arrives mid-debounce.
        btn_raw = 1'b1;
        repeat (4) step_clk();
        resetn = 1'b0;
        btn_raw = 1'b0;
        step_clk();
        resetn = 1'b1;
        repeat (15) step_clk();
        checks++;
        if (count !== 5'd5 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_press: count=%0d wrap=%0b want count=5 wrap=0", count, wrap);
        end
    endtask

    task automatic test_clean_presses();
        for (int i = 0; i < 6; i++) press(1'b0, "clean");
        checks++;
        if (count !== 5'd5) begin
            failures++;
            $display("FAIL clean_final: count=%0d want 5", count);
        end
    endtask

    task automatic test_bounce();
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            btn_raw = (i % 3) != 2;
            step_clk();
            if (wrap !== 1'b0 || count !== model_cnt) bad++;
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step_clk();
            if (wrap !== 1'b0 || count !== model_cnt) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bounce: %0d cycles moved count/wrap, count=%0d want %0d", bad, count, model_cnt);
        end
    endtask

    task automatic test_load_vs_step();
        max_in = 5'd3;
        do_load();
        press(1'b0, "lds_pre");     // 3 -> 2
        press(1'b1, "lds_same");    // load wins: 3
        press(1'b0, "lds_next");    // 2
        checks++;
        if (count !== 5'd2) begin
            failures++;
            $display("FAIL load_step_final: count=%0d want 2", count);
        end
    endtask

    task automatic test_max_lowered();
        max_in = 5'd20;
        do_load();
        max_in = 5'd7;
        press(1'b0, "lower");       // 20 > 7 -> 7
        press(1'b0, "lower_next");  // 6
        checks++;
        if (count !== 5'd6) begin
            failures++;
            $display("FAIL lower_final: count=%0d want 6", count);
        end
    endtask

    task automatic test_max_zero();
        int wraps;
        do_reset(5'd0);
        for (int i = 0; i < 3; i++) press(1'b0, "max0");
        wraps = 0;
        // Back-to-back presses again, now counting wrap pulses from outside.
        fork
            begin
                for (int i = 0; i < 3 * (DB + 18); i++) begin
                    @(negedge clock);
                    if (wrap === 1'b1) wraps++;
                end
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    btn_raw = 1'b1;
                    repeat (DB + 6) step_clk();
                    btn_raw = 1'b0;
                    repeat (12) step_clk();
                end
            end
        join
        checks++;
        if (wraps != 3 || count !== 5'd0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL max0_wraps: wraps=%0d count=%0d zero=%0b want wraps=3 count=0 zero=1",
                     wraps, count, zero);
        end
    endtask

    task automatic test_auto_tick();
        exp_t e;
        int bad;
        bad = 0;
        do_reset(5'd2);
        for (int k = 1; k <= 45; k++) begin
            step_clk();
            if (k % TD == 0) model_cnt = (model_cnt == 5'd0) ? 5'd2 : model_cnt - 5'd1;
            sb.push_back('{model_cnt, model_cnt == 5'd0, k == 30});
            e = sb.pop_front();
            if (count !== e.cnt || zero !== e.z || wrap !== e.w) begin
                bad++;
                $display("FAIL tick_edge%0d: count=%0d wrap=%0b want count=%0d wrap=%0b",
                         k, count, wrap, e.cnt, e.w);
            end
        end
        checks++;
        if (bad != 0) failures++;
        // Reset mid-period must restart the prescaler from 0.
        resetn = 1'b0;
        step_clk();
        resetn = 1'b1;
        repeat (TD - 1) step_clk();
        checks++;
        if (count !== 5'd2) begin
            failures++;
            $display("FAIL tick_restart_hold: count=%0d want 2", count);
        end
        step_clk();
        checks++;
        if (count !== 5'd1) begin
            failures++;
            $display("FAIL tick_restart_step: count=%0d want 1", count);
        end
    endtask

    initial begin
        repeat (2) step_clk();
`ifdef AUTO_TICK_EN
        test_auto_tick();
`else
        test_reset();
        test_clean_presses();
        test_bounce();
        test_load_vs_step();
        test_max_lowered();
        test_max_zero();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
